// File: rtl/ucaspian_pkg.sv
// Shared types and defaults for the ucaspian timestep scheduler.
package ucaspian_pkg;

   localparam int unsigned STEP_W_DEF     = 16;
   localparam int unsigned SETTLE_CYC_DEF = 4;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StStep,
      StSettle,
      StWaitDone
   } sched_state_e;

endpackage

// File: rtl/ucaspian_wdog_cnt.sv
// Step watchdog: counts cycles spent waiting for step completion and flags saturation.
module ucaspian_wdog_cnt (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clr,
   output logic expired
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == 16'hFFFF);

endmodule

// File: rtl/ucaspian_step_sched.sv
// Timestep scheduler: run handshake, clear sequencing, step/settle/wait FSM.
// Optional step watchdog enabled by defining UCASPIAN_STEP_WDOG_EN.
module ucaspian_step_sched
   import ucaspian_pkg::*;
#(
   parameter int unsigned STEP_W     = STEP_W_DEF,
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [STEP_W-1:0] run_steps,
   input  logic              run_vld,
   output logic              run_rdy,
   input  logic              halt,
   input  logic              clr_act_req,
   input  logic              clr_cfg_req,
   output logic              clear_act,
   output logic              clear_config,
   input  logic              clear_done,
   output logic              next_step,
   input  logic              dend_step_done,
   input  logic              neur_step_done,
   output logic              run_done,
   output logic [31:0]       time_count,
   output logic              busy,
   output logic              wdog_err
);

   localparam int unsigned    SetW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SetW-1:0] SetLast = (SETTLE_CYC > 1) ? SetW'(SETTLE_CYC - 1) : '0;

   sched_state_e      state_q, state_d;
   logic [STEP_W-1:0] remaining_q, remaining_d;
   logic [31:0]       time_count_q, time_count_d;
   logic [SetW-1:0]   settle_cnt_q, settle_cnt_d;
   logic              cfg_sel_q, cfg_sel_d;
   logic              halt_seen_q, halt_seen_d;
   logic              run_done_q, run_done_d;
   logic              wdog_err_q, wdog_err_d;
   logic              wdog_expired;
   logic              in_run;

   assign in_run = (state_q == StStep) || (state_q == StSettle) || (state_q == StWaitDone);

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      time_count_d = time_count_q;
      settle_cnt_d = settle_cnt_q;
      cfg_sel_d    = cfg_sel_q;
      halt_seen_d  = halt_seen_q;
      run_done_d   = 1'b0;
      wdog_err_d   = wdog_err_q;

      // The halt latch listens even while frozen so a halt pulse is never lost.
      if (in_run && halt) begin
         halt_seen_d = 1'b1;
      end

      if (enable) begin
         unique case (state_q)
            StIdle: begin
               if (clr_cfg_req) begin
                  state_d   = StClear;
                  cfg_sel_d = 1'b1;
               end else if (clr_act_req) begin
                  state_d   = StClear;
                  cfg_sel_d = 1'b0;
               end else if (run_vld) begin
                  remaining_d = run_steps;
                  halt_seen_d = 1'b0;
                  if (run_steps == '0) begin
                     run_done_d = 1'b1;
                  end else begin
                     state_d = StStep;
                  end
               end
            end
            StClear: begin
               if (clear_done) begin
                  state_d = StIdle;
               end
            end
            StStep: begin
               time_count_d = time_count_q + 32'd1;
               remaining_d  = remaining_q - STEP_W'(1);
               settle_cnt_d = '0;
               state_d      = (SETTLE_CYC == 0) ? StWaitDone : StSettle;
            end
            StSettle: begin
               if (settle_cnt_q == SetLast) begin
                  state_d = StWaitDone;
               end else begin
                  settle_cnt_d = settle_cnt_q + SetW'(1);
               end
            end
            StWaitDone: begin
               if (dend_step_done && neur_step_done) begin
                  if ((remaining_q == '0) || halt_seen_q || halt) begin
                     run_done_d = 1'b1;
                     state_d    = StIdle;
                  end else begin
                     state_d = StStep;
                  end
               end else if (wdog_expired) begin
                  wdog_err_d = 1'b1;
                  run_done_d = 1'b1;
                  state_d    = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         remaining_q  <= '0;
         time_count_q <= '0;
         settle_cnt_q <= '0;
         cfg_sel_q    <= 1'b0;
         halt_seen_q  <= 1'b0;
         run_done_q   <= 1'b0;
         wdog_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         time_count_q <= time_count_d;
         settle_cnt_q <= settle_cnt_d;
         cfg_sel_q    <= cfg_sel_d;
         halt_seen_q  <= halt_seen_d;
         run_done_q   <= run_done_d;
         wdog_err_q   <= wdog_err_d;
      end
   end

`ifdef UCASPIAN_STEP_WDOG_EN
   ucaspian_wdog_cnt u_wdog_cnt (
      .clk     (clk),
      .reset   (reset),
      .run     (enable && (state_q == StWaitDone)),
      .clr     (state_q != StWaitDone),
      .expired (wdog_expired)
   );
   assign wdog_err = wdog_err_q;
`else
   assign wdog_expired = 1'b0;
   assign wdog_err     = wdog_err_q;
`endif

   // A pending clear outranks the run, so ready is withheld rather than faking an accept.
   assign run_rdy      = enable && (state_q == StIdle) && !clr_cfg_req && !clr_act_req;
   assign busy         = (state_q != StIdle);
   assign next_step    = enable && (state_q == StStep);
   assign clear_config = (state_q == StClear) && cfg_sel_q;
   assign clear_act    = (state_q == StClear) && !cfg_sel_q;
   assign run_done     = run_done_q;
   assign time_count   = time_count_q;

endmodule

// File: doc/ucaspian_step_sched.md
UCASPIAN_STEP_SCHED -- requirements
Module: ucaspian_step_sched

Interface
REQ-001 Parameter STEP_W, default 16: width of the requested step count.
REQ-002 Parameter SETTLE_CYC, default 4: cycles after next_step during which done inputs are ignored.
REQ-003 Port clk, input, 1: single clock; all logic rising-edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: low freezes the FSM and all counters.
REQ-006 Port run_steps, input, STEP_W: number of timesteps to execute.
REQ-007 Port run_vld / run_rdy, input / output, 1 each: run command handshake.
REQ-008 Port halt, input, 1: stop the run after the current step completes.
REQ-009 Port clr_act_req / clr_cfg_req, input, 1 each: clear requests, sampled in IDLE only.
REQ-010 Port clear_act / clear_config, output, 1 each: clear strobes to dendrite/neuron/synapse.
REQ-011 Port clear_done, input, 1: clear completion from datapath.
REQ-012 Port next_step, output, 1: single-cycle timestep pulse.
REQ-013 Port dend_step_done / neur_step_done, input, 1 each: per-unit step completion levels.
REQ-014 Port run_done, output, 1: single-cycle pulse when a run ends.
REQ-015 Port time_count, output, 32: total steps issued since reset.
REQ-016 Port busy, output, 1: high in any state other than IDLE.
REQ-017 Port wdog_err, output, 1: sticky step-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, STEP, SETTLE, WAIT_DONE.
REQ-019 IDLE: run_rdy=1; priority clr_cfg_req > clr_act_req > run_vld.
REQ-020 A clear request in IDLE SHALL go to CLEAR and hold the matching strobe (clear_config or clear_act) high from the next cycle until the cycle clear_done=1.
REQ-021 On clear_done, the strobe SHALL drop and the FSM SHALL return to IDLE; clears do not touch time_count.
REQ-022 Run accept (run_vld && run_rdy) SHALL latch run_steps into remaining.
REQ-023 Run accept with run_steps==0 SHALL pulse run_done on the next cycle, with no next_step.
REQ-024 Run accept with run_steps>0 SHALL go to STEP.
REQ-025 STEP SHALL assert next_step for exactly 1 cycle, increment time_count (wraps mod 2^32), decrement remaining, then go to SETTLE.
REQ-026 SETTLE SHALL wait exactly SETTLE_CYC cycles, ignoring the done inputs, then go to WAIT_DONE.
REQ-027 WAIT_DONE SHALL exit only when dend_step_done && neur_step_done in the same cycle.
REQ-028 On that exit: if remaining==0 or halt was seen since run accept, pulse run_done and go to IDLE; else go to STEP.
REQ-029 next_step-to-next_step spacing SHALL be at least SETTLE_CYC+2 cycles.
REQ-030 halt outside a run SHALL be ignored; halt during a run SHALL never truncate a step in progress.
REQ-031 enable=0 SHALL hold state and counters and force next_step=0; a pending pulse is issued after enable returns.
REQ-032 run_vld while busy SHALL be stalled (run_rdy=0), not dropped.

Reset
REQ-033 Reset SHALL force state=IDLE, next_step=0, clear_act=0, clear_config=0, run_done=0, busy=0, run_rdy=1, time_count=0, remaining=0, wdog_err=0, halt latch=0.
REQ-034 Reset mid-run or mid-clear SHALL abort immediately, with no run_done pulse.

Configuration
REQ-035 Macro UCASPIAN_STEP_WDOG_EN: when defined, a 16-bit counter runs in WAIT_DONE; reaching 65535 SHALL set wdog_err (sticky until reset), pulse run_done, and go to IDLE.
REQ-036 Without UCASPIAN_STEP_WDOG_EN, wdog_err SHALL be tied 0 and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-037 The state enum and the SETTLE_CYC/STEP_W defaults SHALL live in package ucaspian_pkg.
REQ-038 The FSM and counters SHALL be flat; one sub-module, ucaspian_wdog_cnt, SHALL implement the watchdog under the macro.

Verification
REQ-039 Reset, then run_steps=3 with both done inputs high 2 cycles after each SETTLE -> exactly 3 next_step pulses, time_count=3, one run_done.
REQ-040 run_steps=0 -> run_done 1 cycle after accept, no next_step, time_count unchanged.
REQ-041 run_steps=10, halt pulsed during step 2 -> exactly 2 next_step pulses, then run_done.
REQ-042 clr_act_req and run_vld both high in IDLE -> clear_act asserted until clear_done, then the run is accepted.
REQ-043 Done inputs held high continuously -> no step exits SETTLE early; spacing = SETTLE_CYC+2 cycles.
REQ-044 With UCASPIAN_STEP_WDOG_EN, neur_step_done held 0 -> wdog_err=1 after 65535 WAIT_DONE cycles, run_done pulse, return to IDLE.
